// File: rtl/rv_enc_defs.sv
// Shared RV32I encoding constants, request op codes and encoder FSM states.
// The ALU control decoder consumes the same opcode/funct3/funct7 values.
package rv_enc_defs;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_U     = 7'b0110111;

  localparam logic [2:0] F3_ADD    = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SRL    = 3'b101;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [6:0] F7_ZERO   = 7'b0000000;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_ADDI = 3'b001,
    OP_LUI  = 3'b010,
    OP_ORI  = 3'b011,
    OP_SLLI = 3'b100,
    OP_SRLI = 3'b101,
    OP_LI   = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_EMIT    = 2'b01,
    ST_EMIT_LO = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    FMT_R = 2'b00,
    FMT_I = 2'b01,
    FMT_U = 2'b10
  } fmt_e;

  function automatic logic fits_simm12(input logic [31:0] imm);
    return (imm[31:11] == '0) || (imm[31:11] == '1);
  endfunction

  // ADDI sign-extends its immediate, so the upper part is pre-compensated.
  function automatic logic [19:0] lui_hi(input logic [31:0] imm);
    return imm[31:12] + {19'b0, imm[11]};
  endfunction

endpackage

// File: rtl/instr_word_encoder_if.sv
// Request and instruction-memory write bus of the instruction word encoder.
// slave = encoder side, master = loader / memory side.
interface instr_word_encoder_if #(
    parameter int ADDR_W = 6
);
    logic              clear_i;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [2:0]        op_i;
    logic [4:0]        rd_i;
    logic [4:0]        rs1_i;
    logic [4:0]        rs2_i;
    logic [31:0]       imm_i;
    logic              wr_valid_o;
    logic              wr_ready_i;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [31:0]       wr_data_o;
    logic [ADDR_W:0]   count_o;
    logic              full_o;
    logic              err_o;

    modport slave (
        input  clear_i, req_valid_i, op_i, rd_i, rs1_i, rs2_i, imm_i, wr_ready_i,
        output req_ready_o, wr_valid_o, wr_addr_o, wr_data_o, count_o, full_o, err_o
    );

    modport master (
        output clear_i, req_valid_i, op_i, rd_i, rs1_i, rs2_i, imm_i, wr_ready_i,
        input  req_ready_o, wr_valid_o, wr_addr_o, wr_data_o, count_o, full_o, err_o
    );
endinterface

// File: rtl/rv_word_format.sv
// Combinational RV32I word assembler: format select plus fields -> 32-bit word.
module rv_word_format
    import rv_enc_defs::*;
(
    input  fmt_e        i_fmt,
    input  logic [2:0]  i_funct3,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [11:0] i_imm12,
    input  logic [19:0] i_imm20,
    output logic [31:0] o_word
);
    always_comb begin
        unique case (i_fmt)
            FMT_R:   o_word = {F7_ZERO, i_rs2, i_rs1, i_funct3, i_rd, OPC_R};
            FMT_I:   o_word = {i_imm12, i_rs1, i_funct3, i_rd, OPC_I};
            FMT_U:   o_word = {i_imm20, i_rd, OPC_U};
            default: o_word = '0;
        endcase
    end
endmodule

// File: rtl/instr_word_encoder.sv
// Encodes field-level requests (including the LI pseudo-op) into RV32I words
// and writes them to sequential instruction-memory addresses.
module instr_word_encoder
    import rv_enc_defs::*;
#(
    parameter int ADDR_W = 6
) (
    input logic                 clk,
    input logic                 reset,
    instr_word_encoder_if.slave bus
);
    localparam int unsigned     CAP_I  = 1 << ADDR_W;
    localparam int unsigned     LAST_I = CAP_I - 1;
    localparam logic [ADDR_W:0] CAP    = CAP_I[ADDR_W:0];
    localparam logic [ADDR_W:0] LAST   = LAST_I[ADDR_W:0];
    localparam logic [ADDR_W:0] ONE    = (ADDR_W+1)'(1);

    state_e          r_state;
    logic            r_wr_valid;
    logic [31:0]     r_wr_data;
    logic [ADDR_W:0] r_count;
    logic            r_err;
    logic            r_li_two;
    logic [4:0]      r_li_rd;
    logic [11:0]     r_li_lo;

    op_e         w_op;
    logic        w_li_fits;
    logic        w_full;
    logic        w_req_ready;
    logic        w_accept;
    logic        w_wr_fire;
    fmt_e        w_fmt;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [11:0] w_imm12;
    logic [19:0] w_imm20;
    logic [31:0] w_word;

    assign w_op        = op_e'(bus.op_i);
    assign w_li_fits   = fits_simm12(bus.imm_i);
    assign w_full      = (r_count == CAP);
    assign w_req_ready = (r_state == ST_IDLE) && !w_full;
    assign w_accept    = bus.req_valid_i && w_req_ready;
    assign w_wr_fire   = r_wr_valid && bus.wr_ready_i;

    // In EMIT the formatter prepares the LI low half; in IDLE it encodes the request.
    always_comb begin
        // NOTE: every field gets a default first so no path can infer a latch.
        w_fmt    = FMT_I;
        w_funct3 = F3_ADD;
        w_rd     = bus.rd_i;
        w_rs1    = bus.rs1_i;
        w_rs2    = bus.rs2_i;
        w_imm12  = bus.imm_i[11:0];
        w_imm20  = bus.imm_i[31:12];
        if (r_state == ST_EMIT) begin
            w_rd    = r_li_rd;
            w_rs1   = r_li_rd;
            w_imm12 = r_li_lo;
        end else begin
            unique case (w_op)
                OP_ADD:  w_fmt = FMT_R;
                OP_LUI:  w_fmt = FMT_U;
                OP_ORI:  w_funct3 = F3_OR;
                OP_SLLI: begin
                    w_funct3 = F3_SLL;
                    w_imm12  = {F7_ZERO, bus.imm_i[4:0]};
                end
                OP_SRLI: begin
                    w_funct3 = F3_SRL;
                    w_imm12  = {F7_ZERO, bus.imm_i[4:0]};
                end
                OP_LI: begin
                    w_rs1 = '0;
                    if (!w_li_fits) begin
                        w_fmt   = FMT_U;
                        w_imm20 = lui_hi(bus.imm_i);
                    end
                end
                default: ;
            endcase
        end
    end

    rv_word_format u_fmt (
        .i_fmt    (w_fmt),
        .i_funct3 (w_funct3),
        .i_rd     (w_rd),
        .i_rs1    (w_rs1),
        .i_rs2    (w_rs2),
        .i_imm12  (w_imm12),
        .i_imm20  (w_imm20),
        .o_word   (w_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            r_state    <= ST_IDLE;
            r_wr_valid <= 1'b0;
            r_wr_data  <= '0;
            r_count    <= '0;
            r_err      <= 1'b0;
            r_li_two   <= 1'b0;
            r_li_rd    <= '0;
            r_li_lo    <= '0;
        end else if (bus.clear_i) begin
            r_state    <= ST_IDLE;
            r_wr_valid <= 1'b0;
            r_count    <= '0;
            r_err      <= 1'b0;
            r_li_two   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        // A two-word LI with a single free slot is dropped, not split.
                        if (w_op == OP_RSVD ||
                            (w_op == OP_LI && !w_li_fits && r_count == LAST)) begin
                            r_err <= 1'b1;
                        end else begin
                            r_wr_data  <= w_word;
                            r_wr_valid <= 1'b1;
                            r_state    <= ST_EMIT;
                            r_li_two   <= (w_op == OP_LI) && !w_li_fits;
                            r_li_rd    <= bus.rd_i;
                            r_li_lo    <= bus.imm_i[11:0];
                        end
                    end
                end
                ST_EMIT: begin
                    if (w_wr_fire) begin
                        r_count <= r_count + ONE;
                        if (r_li_two) begin
                            r_wr_data <= w_word;
                            r_state   <= ST_EMIT_LO;
                        end else begin
                            r_wr_valid <= 1'b0;
                            r_state    <= ST_IDLE;
                        end
                    end
                end
                ST_EMIT_LO: begin
                    if (w_wr_fire) begin
                        r_count    <= r_count + ONE;
                        r_wr_valid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready_o = w_req_ready;
    assign bus.wr_valid_o  = r_wr_valid;
    assign bus.wr_data_o   = r_wr_data;
    assign bus.wr_addr_o   = r_count[ADDR_W-1:0];
    assign bus.count_o     = r_count;
    assign bus.full_o      = w_full;
    assign bus.err_o       = r_err;
endmodule

// File: tb/tb_instr_word_encoder.sv
// Directed bench for instr_word_encoder: a vector table for the encodings plus
// hand sequences for back-pressure, clear, reserved op, full memory and reset.
module tb_instr_word_encoder;
    import rv_enc_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        req_valid;
    logic        wr_ready;
    logic [2:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_word_encoder_if #(.ADDR_W(6)) if6 ();
    instr_word_encoder_if #(.ADDR_W(2)) if2 ();

    assign if6.clear_i     = clear;
    assign if6.req_valid_i = req_valid;
    assign if6.op_i        = op;
    assign if6.rd_i        = rd;
    assign if6.rs1_i       = rs1;
    assign if6.rs2_i       = rs2;
    assign if6.imm_i       = imm;
    assign if6.wr_ready_i  = wr_ready;
    assign if2.clear_i     = clear;
    assign if2.req_valid_i = req_valid;
    assign if2.op_i        = op;
    assign if2.rd_i        = rd;
    assign if2.rs1_i       = rs1;
    assign if2.rs2_i       = rs2;
    assign if2.imm_i       = imm;
    assign if2.wr_ready_i  = wr_ready;

    instr_word_encoder #(.ADDR_W(6)) u_dut6 (.clk(clk), .reset(reset), .bus(if6.slave));
    instr_word_encoder #(.ADDR_W(2)) u_dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        int          nw;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t vecs [13];
    int   exp_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] o, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [31:0] im);
        op = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic check_reset6(input string tag);
        check({tag, " wr_valid"},  32'(if6.wr_valid_o),  32'd0);
        check({tag, " wr_data"},   if6.wr_data_o,        32'd0);
        check({tag, " wr_addr"},   32'(if6.wr_addr_o),   32'd0);
        check({tag, " count"},     32'(if6.count_o),     32'd0);
        check({tag, " full"},      32'(if6.full_o),      32'd0);
        check({tag, " err"},       32'(if6.err_o),       32'd0);
        check({tag, " req_ready"}, 32'(if6.req_ready_o), 32'd1);
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; req_valid = 1'b0; wr_ready = 1'b1;
        op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset6("reset");
        reset = 1'b0;

        vecs[0]  = '{OP_ADD,  5'd3,  5'd1,  5'd2,  32'h0000_0000, 1, 32'h002081B3, 32'h0};
        vecs[1]  = '{OP_SLLI, 5'd5,  5'd5,  5'd0,  32'hFFFF_FFE4, 1, 32'h00429293, 32'h0};
        vecs[2]  = '{OP_SRLI, 5'd5,  5'd5,  5'd0,  32'hFFFF_FFE4, 1, 32'h0042D293, 32'h0};
        vecs[3]  = '{OP_LI,   5'd10, 5'd7,  5'd9,  32'h1234_5FFF, 2, 32'h12346537, 32'hFFF50513};
        vecs[4]  = '{OP_LI,   5'd10, 5'd7,  5'd9,  32'hFFFF_FFFB, 1, 32'hFFB00513, 32'h0};
        vecs[5]  = '{OP_LI,   5'd1,  5'd3,  5'd0,  32'h0000_07FF, 1, 32'h7FF00093, 32'h0};
        vecs[6]  = '{OP_LI,   5'd1,  5'd3,  5'd0,  32'hFFFF_F800, 1, 32'h80000093, 32'h0};
        vecs[7]  = '{OP_LI,   5'd1,  5'd3,  5'd0,  32'h0000_0800, 2, 32'h000010B7, 32'h80008093};
        vecs[8]  = '{OP_LI,   5'd1,  5'd3,  5'd0,  32'hFFFF_F7FF, 2, 32'hFFFFF0B7, 32'h7FF08093};
        vecs[9]  = '{OP_LUI,  5'd2,  5'd9,  5'd9,  32'hABCD_E123, 1, 32'hABCDE137, 32'h0};
        vecs[10] = '{OP_ORI,  5'd4,  5'd3,  5'd8,  32'h0000_0F0F, 1, 32'hF0F1E213, 32'h0};
        vecs[11] = '{OP_ADDI, 5'd31, 5'd31, 5'd1,  32'hABCD_E800, 1, 32'h800F8F93, 32'h0};
        vecs[12] = '{OP_ADD,  5'd7,  5'd31, 5'd31, 32'hFFFF_FFFF, 1, 32'h01FF83B3, 32'h0};

        exp_cnt = 0;
        for (int i = 0; i < 13; i++) begin
            send(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            check($sformatf("v%0d valid0", i), 32'(if6.wr_valid_o), 32'd1);
            check($sformatf("v%0d word0", i),  if6.wr_data_o, vecs[i].w0);
            check($sformatf("v%0d addr0", i),  32'(if6.wr_addr_o), 32'(exp_cnt));
            step();
            exp_cnt++;
            if (vecs[i].nw == 2) begin
                check($sformatf("v%0d valid1", i), 32'(if6.wr_valid_o), 32'd1);
                check($sformatf("v%0d word1", i),  if6.wr_data_o, vecs[i].w1);
                check($sformatf("v%0d addr1", i),  32'(if6.wr_addr_o), 32'(exp_cnt));
                step();
                exp_cnt++;
            end
            check($sformatf("v%0d idle", i),  32'(if6.wr_valid_o),  32'd0);
            check($sformatf("v%0d ready", i), 32'(if6.req_ready_o), 32'd1);
            check($sformatf("v%0d count", i), 32'(if6.count_o),     32'(exp_cnt));
        end

        // Back-pressure in EMIT, then clear while the word is still held.
        wr_ready = 1'b0;
        send(OP_ADD, 5'd3, 5'd1, 5'd2, 32'h0);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("hold%0d data", k),  if6.wr_data_o, 32'h002081B3);
            check($sformatf("hold%0d addr", k),  32'(if6.wr_addr_o), 32'(exp_cnt));
            check($sformatf("hold%0d valid", k), 32'(if6.wr_valid_o), 32'd1);
            check($sformatf("hold%0d ready", k), 32'(if6.req_ready_o), 32'd0);
            step();
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear valid", 32'(if6.wr_valid_o),  32'd0);
        check("clear count", 32'(if6.count_o),     32'd0);
        check("clear err",   32'(if6.err_o),       32'd0);
        check("clear ready", 32'(if6.req_ready_o), 32'd1);
        step();
        check("clear err2",  32'(if6.err_o),       32'd0);
        wr_ready = 1'b1;

        // Reserved op: one-cycle err pulse, nothing written.
        send(OP_RSVD, 5'd1, 5'd1, 5'd1, 32'h1);
        check("rsvd err",    32'(if6.err_o),      32'd1);
        check("rsvd valid",  32'(if6.wr_valid_o), 32'd0);
        step();
        check("rsvd err off", 32'(if6.err_o),     32'd0);
        check("rsvd count",  32'(if6.count_o),    32'd0);
        check("rsvd ready",  32'(if6.req_ready_o), 32'd1);

        // Small memory: fill, full, refuse, then a two-word LI with one slot left.
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(OP_ADDI, 5'(i + 1), 5'd0, 5'd0, 32'(i));
            check($sformatf("fill%0d addr", i), 32'(if2.wr_addr_o), 32'(i));
            step();
        end
        check("full flag",  32'(if2.full_o),      32'd1);
        check("full ready", 32'(if2.req_ready_o), 32'd0);
        check("full count", 32'(if2.count_o),     32'd4);
        send(OP_ADDI, 5'd9, 5'd0, 5'd0, 32'h9);
        check("full refuse", 32'(if2.wr_valid_o), 32'd0);
        step();
        check("full hold",   32'(if2.count_o),    32'd4);
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(OP_ADDI, 5'(i + 1), 5'd0, 5'd0, 32'(i));
            step();
        end
        check("three count", 32'(if2.count_o), 32'd3);
        send(OP_LI, 5'd10, 5'd0, 5'd0, 32'h1234_5000);
        check("li nospace err",   32'(if2.err_o),      32'd1);
        check("li nospace valid", 32'(if2.wr_valid_o), 32'd0);
        step();
        check("li nospace err off", 32'(if2.err_o),       32'd0);
        check("li nospace count",   32'(if2.count_o),     32'd3);
        check("li nospace ready",   32'(if2.req_ready_o), 32'd1);
        step();
        step();

        // Asynchronous reset while the LI low word is held in EMIT_LO.
        clear = 1'b1;
        step();
        clear = 1'b0;
        send(OP_LI, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF);
        step();
        wr_ready = 1'b0;
        check("emit_lo word", if6.wr_data_o, 32'hFFF50513);
        check("emit_lo addr", 32'(if6.wr_addr_o), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset6("async");
        step();
        reset = 1'b0;
        wr_ready = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/instr_word_encoder.md
# instr_word_encoder

Produces RV32I machine words from field-level requests and writes them sequentially into instruction memory. It is the encoder counterpart of the ALU control decoder: it emits the same opcode, funct3 and funct7 fields that the decoder consumes. The block sits between a boot/test program loader and the instruction memory write port. It also expands an LI (load 32-bit immediate) pseudo-op into one or two instructions.

## Interface
- ADDR_W, 6: instruction memory word-address width; capacity is 2**ADDR_W words.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear_i  in  1  synchronous restart: address/count to 0, pending output dropped.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid && ready at a clk edge.
- op_i  in  3  000 ADD, 001 ADDI, 010 LUI, 011 ORI, 100 SLLI, 101 SRLI, 110 LI, 111 reserved.
- rd_i, rs1_i, rs2_i  in  5 each  register indices.
- imm_i  in  32  immediate: I-type uses [11:0]; shifts use [4:0]; LUI uses [31:12]; LI uses all 32 bits.
- wr_valid_o  out  1  word on wr_data_o/wr_addr_o is valid.
- wr_ready_i  in  1  memory accepts the word when valid && ready.
- wr_addr_o  out  ADDR_W  word address.
- wr_data_o  out  32  encoded instruction.
- count_o  out  ADDR_W+1  words written since reset/clear.
- full_o  out  1  count_o == 2**ADDR_W.
- err_o  out  1  one-cycle pulse: request consumed, nothing written.

## Operation
- Encodings, all with funct7 = 0000000:
  - ADD is R-type (opcode 0110011, funct3 000).
  - ADDI/ORI/SLLI/SRLI are I-type (opcode 0010011, funct3 000/110/001/101). Shift immediate field = {7'b0, imm_i[4:0]}.
  - LUI is U-type (opcode 0110111, word = {imm_i[31:12], rd, opcode}).
- Fields not used by an op are ignored.
- LI:
  - If imm_i fits in signed 12 bits (−2048..2047), emit the single word ADDI rd, x0, imm[11:0].
  - Otherwise emit LUI rd, hi then ADDI rd, rd, imm[11:0], where hi = imm[31:12] + imm[11] (20-bit, wraps modulo 2**20).
- FSM states:
  - IDLE: req_ready_o = !full_o. On accept, go to EMIT, except reserved op or no-space LI, which pulse err_o and stay in IDLE.
  - EMIT: present word 1. On write handshake, go to EMIT_LO if LI needs a second word, else IDLE.
  - EMIT_LO: present the ADDI word. On handshake, go to IDLE.
- wr_addr_o = count_o[ADDR_W-1:0]. Count increments on every write handshake.
- LI needing 2 words with exactly 1 free slot: consumed, err_o pulse, nothing written.
- Priority: reset > clear_i > everything else. clear_i in EMIT/EMIT_LO drops the word, goes to IDLE, and suppresses err_o.
- wr_data_o/wr_addr_o stay stable while wr_valid_o && !wr_ready_i.

## Timing
- Reset values: state IDLE, wr_valid_o 0, wr_data_o 0, wr_addr_o 0, count_o 0, full_o 0, err_o 0, req_ready_o 1.
- Accept at edge N: wr_valid_o is high from cycle N+1 (registered output).
- err_o is high in cycle N+1 only.
- Write handshake at edge M:
  - Single-word op: req_ready_o high from M+1.
  - Two-word LI: second word valid from M+1.
- Throughput: one word per cycle inside LI. Otherwise one request per 2 cycles when wr_ready_i is held high.
- full_o rises the cycle after the final write. req_ready_o is low from that cycle on, until clear_i.

## Structure
- Shared package/include `rv_enc_defs`:
  - opcode constants (R 0110011, I 0010011, U 0110111);
  - funct3 constants, funct7 zero;
  - op_i encodings;
  - FSM state encodings.
- The decoder side uses the same funct3/opcode constants.
- One combinational sub-module, `rv_word_format`: (format select, fields, imm) -> 32-bit word. The FSM, counter and handshake live in the top.

## Test plan
- ADD rd=3, rs1=1, rs2=2, wr_ready=1: wr_data 0x002081B3 at addr 0; count_o → 1.
- SLLI rd=5, rs1=5, imm=0xFFFF_FFE4: shamt 4, word 0x00429293. SRLI with the same fields: 0x0042D293.
- LI rd=10, imm=0x12345FFF: LUI 0x12346537 at addr 0, ADDI 0xFFF50513 at addr 1. LI rd=10, imm=−5: single word 0xFFB00513.
- wr_ready_i held low 5 cycles in EMIT: data/addr stable and req_ready_o low; clear_i asserted mid-hold: wr_valid_o drops next cycle, count_o = 0, no err_o.
- ADDR_W=2: four ADDIs fill memory, full_o = 1, req_ready_o = 0. After clear, three ADDIs then LI 0x12345000: err_o pulse, count_o stays 3.
- op_i=111: err_o high for exactly one cycle, no write. Async reset asserted mid-EMIT_LO: all outputs at reset values immediately.
